// File: rtl/hsc_spi_pkg.sv
// Shared constants and types for the SPI register-access slave.
package hsc_spi_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned INSTR_W      = 16;
  localparam int unsigned INSTR_RW_BIT = 15;
  localparam int unsigned INSTR_WL_HI  = 14;
  localparam int unsigned INSTR_WL_LO  = 13;
  localparam int unsigned INSTR_ADDR_W = 13;
  localparam int unsigned BIT_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // W1:W0 transfer length encodings
  typedef enum logic [1:0] {
    WL_ONE    = 2'b00,
    WL_TWO    = 2'b01,
    WL_THREE  = 2'b10,
    WL_STREAM = 2'b11
  } wlen_e;

  // Number of bytes in a counted transfer; streaming has no count.
  function automatic logic [1:0] wlen_bytes(input wlen_e w);
    case (w)
      WL_ONE:   return 2'd1;
      WL_TWO:   return 2'd2;
      WL_THREE: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hsc_spi_sync.sv
// Multi-flop synchronizer with registered rise/fall event detection.
// Edge events are suppressed until the chain holds real pin samples, so a
// pin that differs from the reset value never produces a spurious event.
module hsc_spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   vld_q;
  logic              prev_q;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Edge detect between the last sync stage and its delayed copy
  always_comb begin
    rise_d = vld_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    fall_d = vld_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;
  end

  // Synchronizer chain, fill tracker and edge registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      vld_q  <= '0;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
      prev_q <= sync_q[STAGES-1];
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // level_o is aligned with the edge outputs
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/hsc_spi_slave.sv
// SPI slave (mode 0, MSB first) bridging a 16-bit instruction plus data
// bytes onto a simple single-cycle register read/write port.
module hsc_spi_slave
  import hsc_spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 13,
  parameter bit          ADDR_ASCEND = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 I_clk,
  input  logic                 _I_rstb,
  input  logic                 I_sclk,
  input  logic                 _I_csb,
  input  logic                 I_sdi,
  output logic                 O_sdo,
  output logic                 O_sdo_oe,
  output logic [ADDR_SIZE-1:0] O_addr,
  output logic [DATA_W-1:0]    O_wdata,
  output logic                 O_wen,
  output logic                 O_ren,
  input  logic [DATA_W-1:0]    I_rdata,
  output logic                 O_busy,
  output logic                 O_err
);

  localparam int unsigned AW = ADDR_SIZE;

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic csb_rise, csb_fall, csb_lvl_unused;
  logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

  hsc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(I_clk), .rst_ni(_I_rstb), .d_i(I_sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  hsc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clk_i(I_clk), .rst_ni(_I_rstb), .d_i(_I_csb),
    .level_o(csb_lvl_unused), .rise_o(csb_rise), .fall_o(csb_fall)
  );

  hsc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk_i(I_clk), .rst_ni(_I_rstb), .d_i(I_sdi),
    .level_o(sdi_lvl), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
  );

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [INSTR_W-2:0]     sh_q, sh_d;
  logic                   rw_q, rw_d;
  wlen_e                  mode_q, mode_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   oe_q, oe_d;
  logic                   wen_q, wen_d;
  logic                   ren_q, ren_d;
  logic                   cap_q, cap_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [INSTR_W-1:0]     instr_c;
  logic [DATA_W-1:0]      byte_c;
  logic                   last_c;

  // Next address after a completed byte, wrapping at the address width
  function automatic logic [AW-1:0] addr_step(input logic [AW-1:0] a);
    if (ADDR_ASCEND) return a + AW'(1);
    else             return a - AW'(1);
  endfunction

  assign instr_c = {sh_q, sdi_lvl};
  assign byte_c  = {sh_q[DATA_W-2:0], sdi_lvl};
  assign last_c  = (mode_q != WL_STREAM) &&
                   (2'(byte_cnt_q + 2'd1) == wlen_bytes(mode_q));

  // Transaction FSM and datapath next-state
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_d       = tx_q;
    oe_d       = oe_q;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    cap_d      = ren_q;
    err_d      = 1'b0;

    // Address steps after a write strobe or a read capture
    if (wen_q || cap_q) addr_d = addr_step(addr_q);
    if (cap_q && (state_q == ST_DATA)) tx_d = I_rdata;

    case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d    = ST_INSTR;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      ST_INSTR: begin
        if (csb_rise) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          sh_d      = {sh_q[INSTR_W-3:0], sdi_lvl};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(INSTR_W - 1)) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            rw_d      = instr_c[INSTR_RW_BIT];
            mode_d    = wlen_e'(instr_c[INSTR_WL_HI:INSTR_WL_LO]);
            addr_d    = AW'(instr_c[INSTR_ADDR_W-1:0]);
            ren_d     = instr_c[INSTR_RW_BIT];
            oe_d      = instr_c[INSTR_RW_BIT];
          end
        end
      end
      ST_DATA: begin
        if (csb_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          err_d   = (bit_cnt_q != '0) ||
                    ((mode_q != WL_STREAM) && (byte_cnt_q < wlen_bytes(mode_q)));
        end else begin
          // No shift on the fall after a byte's last rise: the next byte's MSB is already loaded
          if (sclk_fall && rw_q && (bit_cnt_q != '0)) tx_d = {tx_q[DATA_W-2:0], 1'b0};
          if (sclk_rise) begin
            sh_d      = {sh_q[INSTR_W-3:0], sdi_lvl};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
              bit_cnt_d  = '0;
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (!rw_q) begin
                wen_d   = 1'b1;
                wdata_d = byte_c;
              end
              if (last_c) begin
                state_d = ST_DONE;
                oe_d    = 1'b0;
              end else if (rw_q) begin
                ren_d = 1'b1;
              end
            end
          end
        end
      end
      ST_DONE: begin
        if (csb_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge I_clk or negedge _I_rstb) begin
    if (!_I_rstb) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      mode_q     <= WL_ONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      tx_q       <= '0;
      oe_q       <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      cap_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      cap_q      <= cap_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign O_sdo    = tx_q[DATA_W-1];
  assign O_sdo_oe = oe_q;
  assign O_addr   = addr_q;
  assign O_wdata  = wdata_q;
  assign O_wen    = wen_q;
  assign O_ren    = ren_q;
  assign O_busy   = busy_q;
  assign O_err    = err_q;

endmodule

// File: doc/hsc_spi_slave.md
HSC_SPI_SLAVE -- requirements
Module: hsc_spi_slave

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 13, decoded address width, legal range 1..13.
REQ-002 SHALL have parameter ADDR_ASCEND, default 0: 0 decrements the address per byte, 1 increments it.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for I_sclk, _I_csb and I_sdi, legal range 2..4.
REQ-004 SHALL have port I_clk, input, 1 bit: the one system clock; all logic is on its rising edge.
REQ-005 SHALL have port _I_rstb, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port I_sclk, input, 1 bit: serial clock, asynchronous to I_clk, frequency at most I_clk/8.
REQ-007 SHALL have port _I_csb, input, 1 bit: active-low chip select, asynchronous.
REQ-008 SHALL have port I_sdi, input, 1 bit: serial data in, MSB first.
REQ-009 SHALL have port O_sdo, output, 1 bit: serial data out, MSB first.
REQ-010 SHALL have port O_sdo_oe, output, 1 bit: SDO drive enable, high only during the read data phase.
REQ-011 SHALL have port O_addr, output, ADDR_SIZE bits: register address.
REQ-012 SHALL have port O_wdata, output, 8 bits: write data.
REQ-013 SHALL have port O_wen, output, 1 bit: one-cycle write strobe.
REQ-014 SHALL have port O_ren, output, 1 bit: one-cycle read request.
REQ-015 SHALL have port I_rdata, input, 8 bits: read data, valid exactly one I_clk cycle after O_ren.
REQ-016 SHALL have port O_busy, output, 1 bit: high while a transaction is in progress.
REQ-017 SHALL have port O_err, output, 1 bit: one-cycle pulse on an aborted transaction.

Function
REQ-018 SHALL synchronize I_sclk, _I_csb and I_sdi through SYNC_STAGES flops and SHALL detect rise and fall events of the synchronized SCLK.
REQ-019 SHALL implement the FSM IDLE -> INSTR -> DATA -> DONE -> IDLE.
REQ-020 IDLE -> INSTR on synchronized CSB falling.
REQ-021 INSTR SHALL shift 16 bits on SCLK rise events: bit15 = R/W (1 = read), bits14:13 = W1:W0, bits12:0 = address.
REQ-022 Only address bits ADDR_SIZE-1:0 SHALL be used; upper address bits are ignored.
REQ-023 W1:W0 byte count SHALL be: 00 = 1, 01 = 2, 10 = 3, 11 = streaming (unbounded until CSB deasserts).
REQ-024 After the 16th instruction bit, the FSM SHALL enter DATA and load O_addr.
REQ-025 Write, per byte: SHALL sample 8 bits on SCLK rise events; on the cycle after the 8th rise, SHALL pulse O_wen for one cycle with O_wdata and O_addr stable.
REQ-026 Write, per byte: SHALL step O_addr on the following cycle.
REQ-027 Read, per byte: SHALL pulse O_ren the cycle after DATA entry or after the previous byte's 8th rise.
REQ-028 Read, per byte: SHALL capture I_rdata one cycle later into the output shift register.
REQ-029 Read, per byte: SHALL drive the MSB on O_sdo before the next SCLK rise, and SHALL shift on each SCLK fall event.
REQ-030 Read, per byte: SHALL step O_addr after capture.
REQ-031 Address stepping SHALL wrap modulo 2^ADDR_SIZE: descending from 0 to 2^ADDR_SIZE-1; ascending from 2^ADDR_SIZE-1 to 0.
REQ-032 After the counted byte number completes, the FSM SHALL enter DONE, ignore SCLK, and hold O_sdo_oe low until CSB rises.
REQ-033 CSB rising in any state SHALL return the FSM to IDLE within one cycle of the synchronized event.
REQ-034 On CSB rising, a partial byte SHALL be discarded with no O_wen.
REQ-035 CSB rising SHALL pulse O_err if the instruction is incomplete or the bit counter is nonzero, or, in a counted mode, if fewer bytes completed.
REQ-036 O_busy SHALL be high in every state except IDLE.
REQ-037 O_wen and O_ren SHALL never be asserted in the same cycle.

Reset
REQ-038 _I_rstb low SHALL asynchronously force: FSM to IDLE; outputs O_sdo, O_sdo_oe, O_wen, O_ren, O_busy, O_err to 0; O_addr and O_wdata to 0.
REQ-039 _I_rstb low SHALL load the synchronizers with SCLK = 0, CSB = 1, SDI = 0.
REQ-040 Reset deassertion while CSB is low SHALL not start a transaction; a fresh CSB falling edge is required.

Structure
REQ-041 Package hsc_spi_pkg SHALL hold: the FSM state enum, instruction field positions, W1:W0 encodings, and the data width constant 8.
REQ-042 Sub-module hsc_spi_sync SHALL implement one synchronizer plus rise/fall detector.
REQ-043 hsc_spi_sync SHALL be instantiated once per async input.

Verification
REQ-044 Write 1 byte, instr 0x0014, data 0xA5 -> one O_wen with O_addr = 0x14, O_wdata = 0xA5; O_err = 0.
REQ-045 Streaming write, instr 0x6002, ADDR_ASCEND = 0, data 0x11, 0x22, 0x33, 0x44 -> O_wen at 0x002, 0x001, 0x000, 0x1FFF (ADDR_SIZE = 13).
REQ-046 Read 3 bytes, instr 0xC010, ADDR_ASCEND = 1, reg model returns addr+0x40 -> SDO bytes 0x50, 0x51, 0x52; O_ren at 0x10, 0x11, 0x12; no O_wen.
REQ-047 CSB rises after 5 data bits of a 1-byte write -> no O_wen; O_err pulses once; O_busy low; next transaction works.
REQ-048 Extra 8 SCLKs after a completed 1-byte read -> O_sdo_oe stays 0, no extra O_ren.
REQ-049 _I_rstb low mid-transfer -> all outputs 0 immediately.
